radix4_mult_seq: RTL and testbench
==================================

# radix4_mult_seq

Sequential unsigned multiplier that reuses a single 2-bit partial-product unit over several cycles. It latches an operand pair on `start` and retires one radix-4 multiplier digit per clock, accumulating shifted partial products. It signals completion with a one-cycle `done` pulse. It sits between an operand-issuing requester and any consumer of the product, and trades latency for area against a full array multiplier.

## Interface
- `MCAND_W`, default 8: multiplicand width.
- `MPLR_W`, default 8: multiplier width; must be even (one digit = 2 bits).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: request; sampled only in IDLE or DONE.
- `mcand` in MCAND_W: multiplicand, captured on accepted `start`.
- `mplr` in MPLR_W: multiplier, captured on accepted `start`.
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle pulse; `prod` valid.
- `prod` out MCAND_W+MPLR_W: registered product; holds until next completion.

## Operation
- FSM states:
  - IDLE: waits for `start`.
  - RUN: retires one digit per cycle.
  - DONE: one cycle; `done` is high.
- IDLE: on `start`=1, latch `mcand` into `mc_q` and `mplr` into `mp_sh`. Clear `acc` and digit counter `cnt`, then go to RUN.
- RUN, every cycle:
  - Compute `pp = mc_q * mp_sh[1:0]` (0, 1x, 2x or 3x; MCAND_W+2 bits).
  - Update `acc += pp << (2*cnt)`.
  - Shift `mp_sh >>= 2`.
  - Increment `cnt`.
- RUN exit: when `cnt` reaches MPLR_W/2−1 in this cycle, load `prod <= acc + shifted pp` and go to DONE.
- DONE: `start`=1 is accepted exactly as in IDLE (back-to-back operation) and goes to RUN; otherwise go to IDLE.
- `start` during RUN is ignored. No queuing, no error flag.
- Width rules:
  - Unsigned arithmetic throughout.
  - `acc` is MCAND_W+MPLR_W bits and cannot overflow.
  - Zero-extend `pp` before shifting.
- Operands change freely after capture; the in-flight result depends only on latched values.

## Timing
- Reset values: `busy`=0, `done`=0, `prod`=0; state IDLE; `acc`, `cnt`, `mc_q`, `mp_sh` = 0.
- Reset mid-operation: next edge forces IDLE. No `done` is produced and `prod` returns to 0.
- Latency, counted from the edge E0 that samples `start`:
  - `busy` is high for cycles E0..E(N−1), where N = MPLR_W/2.
  - `done` is high in the cycle after edge E(N).
  - Default: `done` follows the sampling edge by 4 edges.
- Throughput: one result per N+1 cycles, including the back-to-back case.
- `prod` changes only on the edge entering DONE.
- `done` and `busy` are never high together.

## Configuration
- `MULT_EARLY_EXIT_EN`, defined:
  - In RUN, if the post-shift `mp_sh` is zero, load `prod` and go to DONE immediately, regardless of `cnt`.
  - Latency becomes 1..N edges.
  - Minimum is one RUN cycle, even for `mplr`=0.
- `MULT_EARLY_EXIT_EN`, undefined: fixed latency of N RUN cycles.
- `prod` values are identical in both builds.

## Structure
- Shared package `mult_pkg` holds:
  - State enum `mult_state_t` (IDLE, RUN, DONE).
  - Digit width constant `DIGIT_W = 2`.
  - Product-width helper function.
- Sub-module `radix4_pp`:
  - Combinational partial-product generator.
  - Inputs: MCAND_W multiplicand and 2-bit digit.
  - Output: MCAND_W+2 value (0, 1x, 2x or 3x).
- The top holds the FSM, counter, shifter and accumulator.

## Test plan
- Reset: hold `rst`=1 for 2 cycles → `busy`=0, `done`=0, `prod`=16'h0000; `start` during reset is ignored.
- Max operands: 8'hFF × 8'hFF → `prod`=16'hFE01; `done` 4 edges after the sampling edge; `busy` high exactly 4 cycles.
- Start during RUN: 13 × 10, then pulse `start` with 9 × 9 two cycles later → a single `done` with `prod`=130; the second request is dropped.
- Back-to-back: 5 × 7, then `start`=1 with 3 × 3 during DONE → `prod`=35 in the first DONE, 9 exactly 5 cycles later; `busy` re-asserts in the cycle after DONE.
- Reset mid-run: assert `rst` at RUN cycle 2 of 200 × 100 → IDLE next edge, no `done`, `prod`=0.
- `MULT_EARLY_EXIT_EN` defined: 200 × 1 → `done` 1 edge after sampling, `prod`=200. 200 × 8'h40 → 4 edges, `prod`=12800. Undefined: both take 4 edges.

Source files
------------

// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
//   Shared definitions for the radix-4 sequential multiplier.
//   - mult_state_t : controller state encoding (IDLE, RUN, DONE)
//   - DIGIT_W      : bits of multiplier retired per RUN cycle
//   - prod_width() : width of the full unsigned product
// -----------------------------------------------------------------------------
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam int DIGIT_W = 2;

  // An unsigned a-bit by b-bit product never needs more than a+b bits.
  function automatic int prod_width(input int mcand_w, input int mplr_w);
    return mcand_w + mplr_w;
  endfunction

endpackage : mult_pkg

// File: rtl/radix4_pp.sv
// -----------------------------------------------------------------------------
// radix4_pp
//   Combinational partial-product generator for one radix-4 multiplier digit.
//   Produces 0, 1x, 2x or 3x the multiplicand, zero-extended by two bits so
//   that 3x never overflows.
//
// Ports
//   mcand_i [MCAND_W-1:0]  multiplicand
//   digit_i [DIGIT_W-1:0]  current multiplier digit
//   pp_o    [MCAND_W+1:0]  mcand_i * digit_i
// -----------------------------------------------------------------------------
module radix4_pp
  import mult_pkg::*;
#(
  parameter int MCAND_W = 8
) (
  input  logic [MCAND_W-1:0] mcand_i,
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [MCAND_W+1:0] pp_o
);

  logic [MCAND_W+1:0] mc_x1;
  logic [MCAND_W+1:0] mc_x2;

  assign mc_x1 = {2'b00, mcand_i};
  assign mc_x2 = {1'b0, mcand_i, 1'b0};

  // NOTE: every combinational output gets a default before the case so no
  // path through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    pp_o = '0;
    unique case (digit_i)
      2'd0: pp_o = '0;
      2'd1: pp_o = mc_x1;
      2'd2: pp_o = mc_x2;
      2'd3: pp_o = mc_x1 + mc_x2;
    endcase
  end

endmodule : radix4_pp

// File: rtl/radix4_mult_seq.sv
// -----------------------------------------------------------------------------
// radix4_mult_seq
//   Sequential unsigned multiplier. An operand pair is latched on an accepted
//   start; one radix-4 multiplier digit (2 bits) is retired per RUN cycle by a
//   single shared partial-product unit, and the shifted partial products are
//   accumulated. Completion is flagged by a one-cycle done pulse, with the
//   registered product held on prod until the next completion.
//
//   MPLR_W must be even.
//
// Build option
//   MULT_EARLY_EXIT_EN : when defined, RUN ends as soon as the remaining
//                        multiplier bits are all zero (1..N RUN cycles instead
//                        of a fixed N). The product is identical either way.
//
// Ports
//   clk                          rising-edge clock
//   rst                          synchronous active-high reset
//   start                        request; sampled only in IDLE or DONE
//   mcand [MCAND_W-1:0]          multiplicand, captured on accepted start
//   mplr  [MPLR_W-1:0]           multiplier, captured on accepted start
//   busy                         high while in RUN
//   done                         one-cycle completion pulse
//   prod  [MCAND_W+MPLR_W-1:0]   registered product
// -----------------------------------------------------------------------------
module radix4_mult_seq
  import mult_pkg::*;
#(
  parameter int MCAND_W = 8,
  parameter int MPLR_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [MCAND_W-1:0]        mcand,
  input  logic [MPLR_W-1:0]         mplr,
  output logic                      busy,
  output logic                      done,
  output logic [MCAND_W+MPLR_W-1:0] prod
);

  localparam int PROD_W = prod_width(MCAND_W, MPLR_W);
  localparam int NDIG   = MPLR_W / DIGIT_W;
  localparam int CNT_W  = (NDIG > 1) ? $clog2(NDIG) : 1;

  mult_state_t         state_q, state_d;
  logic [MCAND_W-1:0]  mc_q, mc_d;
  logic [MPLR_W-1:0]   mp_sh_q, mp_sh_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PROD_W-1:0]   prod_q, prod_d;

  logic [MCAND_W+1:0]  pp;
  logic [PROD_W-1:0]   pp_shifted;
  logic [PROD_W-1:0]   acc_sum;
  logic [MPLR_W-1:0]   mp_next;
  logic [CNT_W:0]      shamt;
  logic                last_digit;
  logic                exit_run;

  radix4_pp #(
    .MCAND_W (MCAND_W)
  ) u_pp (
    .mcand_i (mc_q),
    .digit_i (mp_sh_q[DIGIT_W-1:0]),
    .pp_o    (pp)
  );

  // Digit cnt carries weight 4^cnt, i.e. a left shift of 2*cnt bits.
  assign shamt      = {cnt_q, 1'b0};
  assign pp_shifted = PROD_W'(pp) << shamt;
  assign acc_sum    = acc_q + pp_shifted;
  assign mp_next    = mp_sh_q >> DIGIT_W;
  assign last_digit = (cnt_q == CNT_W'(NDIG - 1));

`ifdef MULT_EARLY_EXIT_EN
  // Once the remaining multiplier bits are zero no further partial product
  // can change the sum, so the current acc_sum is already the final product.
  assign exit_run = last_digit || (mp_next == '0);
`else
  assign exit_run = last_digit;
`endif

  always_comb begin
    state_d = state_q;
    mc_d    = mc_q;
    mp_sh_d = mp_sh_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;

    unique case (state_q)
      // DONE accepts a new request exactly like IDLE for back-to-back use.
      IDLE, DONE: begin
        if (start) begin
          mc_d    = mcand;
          mp_sh_d = mplr;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        acc_d   = acc_sum;
        mp_sh_d = mp_next;
        cnt_d   = cnt_q + CNT_W'(1);
        if (exit_run) begin
          prod_d  = acc_sum;
          state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mc_q    <= '0;
      mp_sh_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      mc_q    <= mc_d;
      mp_sh_q <= mp_sh_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign prod = prod_q;

endmodule : radix4_mult_seq

// File: tb/tb_radix4_mult_seq.sv
// -----------------------------------------------------------------------------
// tb_radix4_mult_seq
//   Scoreboard bench for radix4_mult_seq. The driver pushes the expected
//   product and completion cycle for every accepted request; a monitor on the
//   falling edge pops and compares when done is due, and checks busy, done
//   exclusivity and prod holding between completions.
// -----------------------------------------------------------------------------
module tb_radix4_mult_seq;

  localparam int MCAND_W = 8;
  localparam int MPLR_W  = 8;
  localparam int PROD_W  = MCAND_W + MPLR_W;
  localparam int N       = MPLR_W / 2;

  logic               clk;
  logic               rst;
  logic               start;
  logic [MCAND_W-1:0] mcand;
  logic [MPLR_W-1:0]  mplr;
  logic               busy;
  logic               done;
  logic [PROD_W-1:0]  prod;

  radix4_mult_seq #(
    .MCAND_W (MCAND_W),
    .MPLR_W  (MPLR_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mcand (mcand),
    .mplr  (mplr),
    .busy  (busy),
    .done  (done),
    .prod  (prod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [PROD_W-1:0] prod;
    int                c0;
    int                due;
  } exp_t;

  exp_t              sb_q[$];
  int                checks = 0;
  int                errors = 0;
  bit                chk_busy = 1'b0;
  logic [PROD_W-1:0] last_prod = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference latency: N digits, or with early exit the count of significant
  // radix-4 digits of the multiplier (at least one).
  function automatic int exp_latency(input int b);
    int d;
`ifdef MULT_EARLY_EXIT_EN
    d = 1;
    while ((b >> (2 * d)) != 0) d++;
`else
    d = N;
`endif
    return d;
  endfunction

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin
    exp_t e;
    logic exp_busy;
    if (rst) last_prod = '0;
    check("busy_done_excl", 32'(busy & done), 32'd0);
    if (sb_q.size() != 0 && sb_q[0].due == cyc) begin
      e = sb_q.pop_front();
      check("done_at_due", 32'(done), 32'd1);
      check("prod", 32'(prod), 32'(e.prod));
      last_prod = e.prod;
    end else begin
      check("no_spurious_done", 32'(done), 32'd0);
      if (chk_busy) check("prod_hold", 32'(prod), 32'(last_prod));
    end
    if (chk_busy) begin
      exp_busy = (sb_q.size() != 0) && (cyc >= sb_q[0].c0) && (cyc < sb_q[0].due);
      check("busy", 32'(busy), 32'(exp_busy));
    end
  end

  // ----------------------------------------------------------------- driver
  // Called at a falling edge with the DUT in IDLE or DONE. Returns with the
  // request sampled and the operands scrambled; due is the done cycle.
  task automatic issue(input int a, input int b, input int expv, input bit push, output int due);
    exp_t e;
    start = 1'b1;
    mcand = MCAND_W'(a);
    mplr  = MPLR_W'(b);
    e.prod = PROD_W'(expv);
    e.c0   = cyc + 1;
    e.due  = e.c0 + exp_latency(b);
    due    = e.due;
    if (push) sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    mcand = MCAND_W'($urandom);
    mplr  = MPLR_W'($urandom);
  endtask

  // Waits until the DONE cycle; optionally throws ignored starts during RUN.
  task automatic wait_done(input int due, input bit noise);
    while (cyc < due) begin
      if (noise && ($urandom_range(0, 2) == 0)) begin
        start = 1'b1;
        mcand = MCAND_W'($urandom);
        mplr  = MPLR_W'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int due;
    int a, b;

    // Reset with a start request present: it must be ignored.
    rst   = 1'b1;
    start = 1'b1;
    mcand = 8'hAB;
    mplr  = 8'hCD;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_prod", 32'(prod), 32'h0000);
    rst   = 1'b0;
    start = 1'b0;
    chk_busy = 1'b1;
    repeat (3) @(negedge clk);

    // Max operands.
    issue(8'hFF, 8'hFF, 16'hFE01, 1'b1, due);
    wait_done(due, 1'b0);
    repeat (2) @(negedge clk);

    // Start during RUN is dropped.
    issue(13, 10, 130, 1'b1, due);
    start = 1'b1;
    mcand = 8'd9;
    mplr  = 8'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done(due, 1'b0);
    repeat (6) @(negedge clk);

    // Back-to-back: second request accepted in the DONE cycle.
    issue(5, 7, 35, 1'b1, due);
    wait_done(due, 1'b0);
    issue(3, 3, 9, 1'b1, due);
    wait_done(due, 1'b0);
    repeat (2) @(negedge clk);

    // Early-exit sensitive operands.
    issue(200, 1, 200, 1'b1, due);
    wait_done(due, 1'b0);
    issue(200, 8'h40, 12800, 1'b1, due);
    wait_done(due, 1'b0);
    issue(77, 0, 0, 1'b1, due);
    wait_done(due, 1'b0);
    @(negedge clk);
    issue(8'hFF, 8'hFF, 16'hFE01, 1'b1, due);
    wait_done(due, 1'b0);
    @(negedge clk);

    // Reset in RUN cycle 2: no done, prod back to 0.
    chk_busy = 1'b0;
    issue(200, 100, 0, 1'b0, due);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_prod", 32'(prod), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk_busy = 1'b1;
    repeat (8) @(negedge clk);

    // Randomized traffic with back-to-back, idle gaps and ignored starts.
    for (int i = 0; i < 60; i++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      if ($urandom_range(0, 7) == 0) a = 255;
      if ($urandom_range(0, 7) == 0) b = $urandom_range(0, 3) << (2 * $urandom_range(0, 3));
      issue(a, b, a * b, 1'b1, due);
      wait_done(due, $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (N + 3) @(negedge clk);
    check("queue_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_radix4_mult_seq
